mps_memory: RTL and testbench

Memory responder for the MPS CPU: it serves the CPU's instruction-fetch and data-memory ports from on-chip RAMs. Instruction reads and data reads are combinational, and data writes are synchronous. A byte-stream program loader writes instruction memory while it holds the CPU in reset. The block sits beside the CPU in the top level and drives the CPU's `nreset` input.

---
 rtl/mps_pkg.sv | 19 +
 rtl/mps_mem_loader.sv | 113 +++++++++++
 rtl/mps_memory.sv | 71 +++++++
 tb/tb_mps_memory.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mps_pkg.sv
// mps_pkg: constants and types shared across the MPS memory slice.
//   - default RAM geometry (kept in step with the CPU configuration)
//   - loader FSM state encoding
package mps_pkg;

    localparam int MPS_IMEM_ADDR_WIDTH = 8;
    localparam int MPS_IMEM_DATA_WIDTH = 16;
    localparam int MPS_DMEM_ADDR_WIDTH = 8;
    localparam int MPS_DMEM_DATA_WIDTH = 8;

    typedef enum logic [2:0] {
        RUN    = 3'd0,
        COUNT  = 3'd1,
        BYTES  = 3'd2,
        WRITE  = 3'd3,
        FINISH = 3'd4
    } load_state_t;

endpackage

// File: rtl/mps_mem_loader.sv
// mps_mem_loader: byte-stream program loader for instruction memory.
// Holds the CPU in reset while a program streams in: a count byte N is
// followed by N big-endian words of IMEM_DATA_WIDTH/8 bytes each.
// Ports:
//   clock, nreset            clock, synchronous active-low reset
//   load_start               request a load (honoured only in RUN)
//   load_data/valid/ready    byte stream handshake
//   load_done                one-cycle pulse when the load completes
//   imem_we/waddr/wdata      instruction RAM write port
//   cpu_nreset               registered reset to the CPU
module mps_mem_loader
    import mps_pkg::*;
#(
    parameter int IMEM_ADDR_WIDTH = MPS_IMEM_ADDR_WIDTH,
    parameter int IMEM_DATA_WIDTH = MPS_IMEM_DATA_WIDTH
) (
    input  logic                       clock,
    input  logic                       nreset,
    input  logic                       load_start,
    input  logic [7:0]                 load_data,
    input  logic                       load_valid,
    output logic                       load_ready,
    output logic                       load_done,
    output logic                       imem_we,
    output logic [IMEM_ADDR_WIDTH-1:0] imem_waddr,
    output logic [IMEM_DATA_WIDTH-1:0] imem_wdata,
    output logic                       cpu_nreset
);

    localparam int BPW   = IMEM_DATA_WIDTH / 8;
    localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

    load_state_t                state, next_state;
    logic [IMEM_ADDR_WIDTH-1:0] addr;
    logic [7:0]                 count;
    logic [IDX_W-1:0]           byte_idx;
    logic [IMEM_DATA_WIDTH-1:0] word;
    logic                       last_byte;

    assign last_byte  = (byte_idx == IDX_W'(BPW - 1));
    assign imem_waddr = addr;
    assign imem_wdata = word;

    always_comb begin
        next_state = state;
        load_ready = 1'b0;
        load_done  = 1'b0;
        imem_we    = 1'b0;
        case (state)
            RUN: begin
                if (load_start)
                    next_state = COUNT;
            end
            COUNT: begin
                load_ready = 1'b1;
                if (load_valid)
                    next_state = (load_data == 8'd0) ? FINISH : BYTES;
            end
            BYTES: begin
                load_ready = 1'b1;
                if (load_valid && last_byte)
                    next_state = WRITE;
            end
            WRITE: begin
                imem_we    = 1'b1;
                // count still holds the pre-decrement value here
                next_state = (count == 8'd1) ? FINISH : BYTES;
            end
            FINISH: begin
                load_done  = 1'b1;
                next_state = RUN;
            end
            default: next_state = RUN;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!nreset) begin
            state      <= RUN;
            cpu_nreset <= 1'b0;
            addr       <= '0;
            count      <= '0;
            byte_idx   <= '0;
            word       <= '0;
        end else begin
            state      <= next_state;
            // release the CPU on the same edge that lands in RUN
            cpu_nreset <= (next_state == RUN);
            case (state)
                COUNT: begin
                    if (load_valid) begin
                        count    <= load_data;
                        addr     <= '0;
                        byte_idx <= '0;
                    end
                end
                BYTES: begin
                    if (load_valid) begin
                        word     <= (word << 8) | IMEM_DATA_WIDTH'(load_data);
                        byte_idx <= last_byte ? '0 : byte_idx + 1'b1;
                    end
                end
                WRITE: begin
                    // address wraps naturally at the RAM depth
                    addr  <= addr + 1'b1;
                    count <= count - 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mps_memory.sv
// mps_memory: instruction and data RAMs serving the MPS CPU, plus the
// program loader that owns the CPU reset.
// Ports:
//   clock, nreset                      clock, synchronous active-low reset
//   imem_addr -> imem_value            combinational instruction fetch
//   dmem_addr/wenable/wvalue/rvalue    combinational read, synchronous write
//   cpu_nreset                         registered reset to the CPU
//   load_start/data/valid/ready/done   program loader stream
module mps_memory
    import mps_pkg::*;
#(
    parameter int IMEM_ADDR_WIDTH = MPS_IMEM_ADDR_WIDTH,
    parameter int IMEM_DATA_WIDTH = MPS_IMEM_DATA_WIDTH,
    parameter int DMEM_ADDR_WIDTH = MPS_DMEM_ADDR_WIDTH,
    parameter int DMEM_DATA_WIDTH = MPS_DMEM_DATA_WIDTH
) (
    input  logic                       clock,
    input  logic                       nreset,
    input  logic [IMEM_ADDR_WIDTH-1:0] imem_addr,
    output logic [IMEM_DATA_WIDTH-1:0] imem_value,
    input  logic [DMEM_ADDR_WIDTH-1:0] dmem_addr,
    input  logic                       dmem_wenable,
    input  logic [DMEM_DATA_WIDTH-1:0] dmem_wvalue,
    output logic [DMEM_DATA_WIDTH-1:0] dmem_rvalue,
    output logic                       cpu_nreset,
    input  logic                       load_start,
    input  logic [7:0]                 load_data,
    input  logic                       load_valid,
    output logic                       load_ready,
    output logic                       load_done
);

    logic [IMEM_DATA_WIDTH-1:0] imem [2**IMEM_ADDR_WIDTH];
    logic [DMEM_DATA_WIDTH-1:0] dmem [2**DMEM_ADDR_WIDTH];

    logic                       imem_we;
    logic [IMEM_ADDR_WIDTH-1:0] imem_waddr;
    logic [IMEM_DATA_WIDTH-1:0] imem_wdata;

    mps_mem_loader #(
        .IMEM_ADDR_WIDTH(IMEM_ADDR_WIDTH),
        .IMEM_DATA_WIDTH(IMEM_DATA_WIDTH)
    ) u_loader (
        .clock      (clock),
        .nreset     (nreset),
        .load_start (load_start),
        .load_data  (load_data),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_done  (load_done),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .cpu_nreset (cpu_nreset)
    );

    assign imem_value  = imem[imem_addr];
    assign dmem_rvalue = dmem[dmem_addr];

    always_ff @(posedge clock) begin
        if (imem_we)
            imem[imem_waddr] <= imem_wdata;
    end

    // CPU stores are dropped while the CPU is held in reset
    always_ff @(posedge clock) begin
        if (dmem_wenable && cpu_nreset)
            dmem[dmem_addr] <= dmem_wvalue;
    end

endmodule

// File: tb/tb_mps_memory.sv
module tb_mps_memory;

    localparam int K_IMEM = 0, K_IMEM2 = 1, K_DMEM = 2, K_CNR = 3,
                   K_RDY = 4, K_DONE = 5, K_DCNT = 6, K_CNR2 = 7;

    logic        clock = 1'b0;
    logic        nreset;
    logic [7:0]  imem_addr;
    logic [1:0]  imem_addr2;
    logic [15:0] imem_value, imem_value2;
    logic [7:0]  dmem_addr, dmem_wvalue, dmem_rvalue, dmem_rvalue2;
    logic        dmem_wenable;
    logic        cpu_nreset, cpu_nreset2;
    logic        load_start, load_valid;
    logic [7:0]  load_data;
    logic        load_ready, load_ready2, load_done, load_done2;

    always #5 clock = ~clock;

    mps_memory dut (
        .clock(clock), .nreset(nreset),
        .imem_addr(imem_addr), .imem_value(imem_value),
        .dmem_addr(dmem_addr), .dmem_wenable(dmem_wenable),
        .dmem_wvalue(dmem_wvalue), .dmem_rvalue(dmem_rvalue),
        .cpu_nreset(cpu_nreset), .load_start(load_start),
        .load_data(load_data), .load_valid(load_valid),
        .load_ready(load_ready), .load_done(load_done)
    );

    // small instruction RAM to exercise address wrap
    mps_memory #(.IMEM_ADDR_WIDTH(2)) dut2 (
        .clock(clock), .nreset(nreset),
        .imem_addr(imem_addr2), .imem_value(imem_value2),
        .dmem_addr(dmem_addr), .dmem_wenable(dmem_wenable),
        .dmem_wvalue(dmem_wvalue), .dmem_rvalue(dmem_rvalue2),
        .cpu_nreset(cpu_nreset2), .load_start(load_start),
        .load_data(load_data), .load_valid(load_valid),
        .load_ready(load_ready2), .load_done(load_done2)
    );

    typedef struct {
        int          kind;
        logic [15:0] val;
        string       name;
    } exp_t;

    exp_t        q[$];
    int          vectors = 0, miscompares = 0;
    int          done_cnt = 0, exp_done = 0, stall = 0;
    logic [15:0] wv [8];

    task automatic expect_(input int kind, input logic [15:0] val, input string name);
        exp_t e;
        e.kind = kind; e.val = val; e.name = name;
        q.push_back(e);
    endtask

    // monitor: counts done pulses and checks queued expectations at negedge
    initial begin
        exp_t        e;
        logic [15:0] act;
        forever begin
            @(negedge clock);
            if (load_done === 1'b1) done_cnt++;
            while (q.size() > 0) begin
                e = q.pop_front();
                case (e.kind)
                    K_IMEM:  act = imem_value;
                    K_IMEM2: act = imem_value2;
                    K_DMEM:  act = {8'h00, dmem_rvalue};
                    K_CNR:   act = {15'h0, cpu_nreset};
                    K_RDY:   act = {15'h0, load_ready};
                    K_DONE:  act = {15'h0, load_done};
                    K_DCNT:  act = 16'(done_cnt);
                    K_CNR2:  act = {15'h0, cpu_nreset2};
                    default: act = 'x;
                endcase
                vectors++;
                if (act !== e.val) begin
                    miscompares++;
                    $display("FAIL %s: got %h expected %h", e.name, act, e.val);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clock); #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit got;
        for (int s = 0; s < stall; s++) begin
            expect_(K_CNR, 16'd0, "cnr_stall");
            cyc();
        end
        load_valid = 1'b1;
        load_data  = b;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            expect_(K_CNR, 16'd0, "cnr_load");
            @(negedge clock);
            got = load_ready;
            cyc();
        end
        load_valid = 1'b0;
        if (!got) begin
            vectors++; miscompares++;
            $display("FAIL byte_accept: got no ready expected ready within 20 cycles");
        end
    endtask

    task automatic do_load(input int n, input bit poke, input bit start_wr);
        load_start = 1'b1;
        if (start_wr) begin
            dmem_addr = 8'h20; dmem_wvalue = 8'h77; dmem_wenable = 1'b1;
        end
        expect_(K_CNR, 16'd1, "cnr_pre_start");
        cyc();
        load_start = 1'b0; dmem_wenable = 1'b0;
        send_byte(8'(n));
        for (int k = 0; k < n; k++) begin
            if (poke && k == 0) begin
                load_start = 1'b1;
                dmem_addr = 8'h10; dmem_wvalue = 8'hFF; dmem_wenable = 1'b1;
            end
            send_byte(wv[k][15:8]);
            load_start = 1'b0; dmem_wenable = 1'b0;
            send_byte(wv[k][7:0]);
        end
        if (n > 0) begin
            expect_(K_CNR, 16'd0, "cnr_write");
            expect_(K_DONE, 16'd0, "done_in_write");
            cyc();
        end
        exp_done++;
        expect_(K_DONE, 16'd1, "done_pulse");
        expect_(K_DCNT, 16'(exp_done), "done_count");
        expect_(K_CNR, 16'd0, "cnr_finish");
        cyc();
        expect_(K_CNR, 16'd1, "cnr_run");
        expect_(K_RDY, 16'd0, "rdy_run");
        expect_(K_DONE, 16'd0, "done_clear");
        cyc();
    endtask

    task automatic chk_imem(input logic [7:0] a, input logic [15:0] v, input string name);
        imem_addr = a; expect_(K_IMEM, v, name); cyc();
    endtask

    task automatic chk_imem2(input logic [1:0] a, input logic [15:0] v, input string name);
        imem_addr2 = a; expect_(K_IMEM2, v, name); cyc();
    endtask

    task automatic chk_dmem(input logic [7:0] a, input logic [7:0] v, input string name);
        dmem_addr = a; expect_(K_DMEM, {8'h00, v}, name); cyc();
    endtask

    initial begin
        nreset = 1'b0; imem_addr = '0; imem_addr2 = '0;
        dmem_addr = '0; dmem_wvalue = '0; dmem_wenable = 1'b0;
        load_start = 1'b0; load_valid = 1'b0; load_data = '0;

        // reset held for three cycles
        for (int i = 0; i < 3; i++) begin
            cyc();
            expect_(K_CNR, 16'd0, "rst_cnr");
            expect_(K_RDY, 16'd0, "rst_rdy");
            expect_(K_DONE, 16'd0, "rst_done");
        end
        nreset = 1'b1;
        cyc();
        expect_(K_CNR, 16'd1, "cnr_after_release");
        expect_(K_RDY, 16'd0, "rdy_after_release");

        // data write / read
        dmem_addr = 8'h11; dmem_wvalue = 8'h33; dmem_wenable = 1'b1; cyc();
        dmem_addr = 8'h10; dmem_wvalue = 8'h5A; cyc();
        dmem_wenable = 1'b0;
        chk_dmem(8'h10, 8'h5A, "dmem_10");
        chk_dmem(8'h11, 8'h33, "dmem_11_kept");

        // preload, then two-word load at full rate
        wv[0] = 16'h1111; wv[1] = 16'h2222; wv[2] = 16'h3333;
        do_load(3, 1'b0, 1'b0);
        wv[0] = 16'h1234; wv[1] = 16'hABCD;
        do_load(2, 1'b0, 1'b0);
        chk_imem(8'd0, 16'h1234, "load2_w0");
        chk_imem(8'd1, 16'hABCD, "load2_w1");
        chk_imem(8'd2, 16'h3333, "load2_w2_kept");

        // same stream with a stalled source
        wv[0] = 16'h5555; wv[1] = 16'h6666; wv[2] = 16'h7777;
        do_load(3, 1'b0, 1'b0);
        wv[0] = 16'h1234; wv[1] = 16'hABCD;
        stall = 4;
        do_load(2, 1'b0, 1'b0);
        stall = 0;
        chk_imem(8'd0, 16'h1234, "stall_w0");
        chk_imem(8'd1, 16'hABCD, "stall_w1");
        chk_imem(8'd2, 16'h7777, "stall_w2_kept");

        // N=0 with a CPU store on the load_start edge
        do_load(0, 1'b0, 1'b1);
        chk_imem(8'd0, 16'h1234, "n0_imem_kept");
        chk_dmem(8'h20, 8'h77, "store_on_start");

        // store and second load_start during a load are ignored
        wv[0] = 16'hBEEF; wv[1] = 16'hCAFE;
        do_load(2, 1'b1, 1'b0);
        expect_(K_CNR, 16'd1, "no_restart_cnr");
        expect_(K_RDY, 16'd0, "no_restart_rdy");
        expect_(K_DCNT, 16'(exp_done), "no_restart_done");
        cyc();
        chk_dmem(8'h10, 8'h5A, "dmem_gated");
        chk_imem(8'd0, 16'hBEEF, "poke_w0");
        chk_imem(8'd1, 16'hCAFE, "poke_w1");

        // reset after the first word is written
        load_start = 1'b1; cyc(); load_start = 1'b0;
        send_byte(8'h02); send_byte(8'h11); send_byte(8'h22);
        cyc();  // WRITE edge
        nreset = 1'b0;
        cyc();
        expect_(K_CNR, 16'd0, "midrst_cnr");
        expect_(K_RDY, 16'd0, "midrst_rdy");
        expect_(K_DONE, 16'd0, "midrst_done");
        nreset = 1'b1;
        cyc();
        expect_(K_CNR, 16'd1, "midrst_release");
        expect_(K_RDY, 16'd0, "midrst_run");
        chk_imem(8'd0, 16'h1122, "midrst_w0");
        chk_imem(8'd1, 16'hCAFE, "midrst_w1_kept");

        // wrap on a 4-entry instruction RAM
        wv[0] = 16'h1001; wv[1] = 16'h2002; wv[2] = 16'h3003;
        wv[3] = 16'h4004; wv[4] = 16'h5005;
        do_load(5, 1'b0, 1'b0);
        expect_(K_CNR2, 16'd1, "wrap_cnr");
        chk_imem2(2'd0, 16'h5005, "wrap_w0");
        chk_imem2(2'd1, 16'h2002, "wrap_w1");
        chk_imem2(2'd3, 16'h4004, "wrap_w3");
        chk_imem(8'd4, 16'h5005, "nowrap_w4");

        cyc();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
